fpu_op_master: RTL
==================

// Module: fpu_op_master
// PURPOSE
// - Initiator side of the per-unit stb/ack operand/result handshake used by the adder, multiplier and divider.
// - Accepts one command {op, a, b} over valid/ready and sequences operand A, then operand B, into the selected unit.
// - Collects output_z with a one-cycle ack and returns it to the consumer over valid/ready.
// - Sits between the instruction/command source and the three float units, replacing static strobe selection.
// PARAMETERS
// - WIDTH           32    operand/result width (IEEE-754 single)
// - TIMEOUT_CYCLES  4096  WAIT_Z watchdog limit; used only with FPU_OP_MASTER_TIMEOUT_EN
// PORTS
// - clk          in   1        single clock; all logic on rising edge
// - rst          in   1        asynchronous, active-low reset
// - cmd_valid    in   1        command present
// - cmd_ready    out  1        command accepted when valid&ready
// - cmd_op       in   2        00 add, 01 mul, 10 div, 11 illegal
// - cmd_a        in   WIDTH    operand A
// - cmd_b        in   WIDTH    operand B
// - unit_a       out  WIDTH    operand A bus, shared by all units
// - unit_b       out  WIDTH    operand B bus, shared by all units
// - unit_a_stb   out  3        one-hot A strobe [0]add [1]mul [2]div
// - unit_a_ack   in   3        per-unit A acknowledge
// - unit_b_stb   out  3        one-hot B strobe
// - unit_b_ack   in   3        per-unit B acknowledge
// - unit_z       in   3*WIDTH  results; unit i at [i*WIDTH +: WIDTH]
// - unit_z_stb   in   3        per-unit result strobe
// - unit_z_ack   out  3        one-hot result acknowledge
// - rsp_valid    out  1        result present
// - rsp_ready    in   1        consumer accepts result
// - rsp_z        out  WIDTH    result
// - rsp_err      out  1        1 = illegal op (or timeout when enabled); rsp_z = 0
// BEHAVIOUR
// - Reset: state IDLE; cmd_ready=1; all stb/ack=0; rsp_valid=0; rsp_z=0; rsp_err=0; unit_a/unit_b=0.
// - FSM: IDLE -> SEND_A -> SEND_B -> WAIT_Z -> RESP -> IDLE.
// - IDLE: cmd_ready=1; on valid&ready register op/a/b, cmd_ready=0 next cycle.
//   Op 11 goes directly to RESP with rsp_err=1, rsp_z=0. No unit is touched.
// - SEND_A: unit_a_stb[op]=1 and unit_a held stable until unit_a_ack[op]=1 seen at an edge.
//   Drop the stb the following cycle; go to SEND_B.
// - SEND_B: same rule with unit_b_stb/unit_b_ack. On ack go to WAIT_Z.
// - WAIT_Z: when unit_z_stb[op]=1, capture unit_z slice into rsp_z and pulse unit_z_ack[op] for exactly one cycle.
//   Go to RESP. Strobes/acks of non-selected units are ignored.
// - RESP: rsp_valid=1, rsp_z/rsp_err stable until rsp_ready; then rsp_valid=0, return to IDLE.
// - Min latency cmd accept -> rsp_valid: 3 cycles + unit compute time. Throughput: one command in flight.
// - Simultaneous ack arrival with stb assertion counts (ack sampled at edge while stb high).
// - At most one bit of any stb/ack vector is ever high. stb never drops before its ack.
// - Reset mid-operation: immediate return to reset values. The command in flight is discarded; no response is issued.
// CONFIGURATION
// - FPU_OP_MASTER_TIMEOUT_EN defined: a counter clears on entry to WAIT_Z.
//   At TIMEOUT_CYCLES cycles without unit_z_stb, go to RESP with rsp_err=1, rsp_z=0. No z_ack is issued.
// - FPU_OP_MASTER_TIMEOUT_EN undefined: no counter; WAIT_Z waits indefinitely; rsp_err set only for op 11.
// STRUCTURE
// - fpu_pkg: op codes OP_ADD/OP_MUL/OP_DIV/OP_ILL, FSM state enum, op->one-hot decode function.
// - Sub-module fpu_op_watchdog: counter + expiry flag, instantiated only under the macro.
// - All other logic stays in this module.
// TESTING
// - add 0x3F800000+0x40000000: A,B stb on bit0 only; model acks after 2 cycles -> rsp_z=0x40400000, err=0, one z_ack pulse.
// - mul 0x40400000*0x40800000 with rsp_ready held low 5 cycles -> rsp_z=0x41400000 held stable; no new cmd_ready until accepted.
// - div 0x41200000/0x40000000, unit_a_ack same cycle as stb -> B phase next cycle; rsp_z=0x40A00000.
// - op=11 -> rsp_valid 1 cycle after accept, err=1, z=0; all unit stb stay 0.
// - rst low during WAIT_Z -> all outputs at reset values next edge; no rsp_valid afterwards; next add completes normally.
// - macro on, TIMEOUT_CYCLES=16, unit never strobes z -> rsp_err=1 exactly 16 cycles after WAIT_Z entry; unit_z_ack never high.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - op codes, FSM states and op decode shared by fpu_op_master
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_DIV = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND_A = 3'd1,
        ST_SEND_B = 3'd2,
        ST_WAIT_Z = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // Unit select: bit0 adder, bit1 multiplier, bit2 divider; illegal selects nothing.
    function automatic logic [2:0] op_onehot(input op_e op);
        case (op)
            OP_ADD:  op_onehot = 3'b001;
            OP_MUL:  op_onehot = 3'b010;
            OP_DIV:  op_onehot = 3'b100;
            default: op_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/fpu_op_watchdog.sv
// rtl/fpu_op_watchdog.sv - WAIT_Z cycle counter with expiry flag (FPU_OP_MASTER_TIMEOUT_EN builds)
module fpu_op_watchdog #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(LIMIT) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = run ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Fires on the last counted cycle so the FSM leaves exactly LIMIT cycles after entry.
    assign expired = run && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/fpu_op_master.sv
// rtl/fpu_op_master.sv - command-to-unit stb/ack sequencer for add/mul/div; FPU_OP_MASTER_TIMEOUT_EN adds WAIT_Z watchdog
module fpu_op_master
    import fpu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    output logic [WIDTH-1:0]   unit_a,
    output logic [WIDTH-1:0]   unit_b,
    output logic [2:0]         unit_a_stb,
    input  logic [2:0]         unit_a_ack,
    output logic [2:0]         unit_b_stb,
    input  logic [2:0]         unit_b_ack,
    input  logic [3*WIDTH-1:0] unit_z,
    input  logic [2:0]         unit_z_stb,
    output logic [2:0]         unit_z_ack,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_z,
    output logic               rsp_err
);
    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [2:0]       sel_q, sel_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [WIDTH-1:0] unit_a_q, unit_a_d, unit_b_q, unit_b_d;
    logic [2:0]       a_stb_q, a_stb_d, b_stb_q, b_stb_d, z_ack_q, z_ack_d;
    logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] rsp_z_q, rsp_z_d;
    logic [WIDTH-1:0] z_sel;
    logic             wdog_expired;

`ifdef FPU_OP_MASTER_TIMEOUT_EN
    fpu_op_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst),
        .run     (state_q == ST_WAIT_Z),
        .expired (wdog_expired)
    );
`else
    // Watchdog compiled out: WAIT_Z waits for the unit indefinitely.
    assign wdog_expired = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        case (op_q)
            OP_MUL:  z_sel = unit_z[WIDTH +: WIDTH];
            OP_DIV:  z_sel = unit_z[2*WIDTH +: WIDTH];
            default: z_sel = unit_z[0 +: WIDTH];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sel_d       = sel_q;
        cmd_ready_d = cmd_ready_q;
        unit_a_d    = unit_a_q;
        unit_b_d    = unit_b_q;
        a_stb_d     = a_stb_q;
        b_stb_d     = b_stb_q;
        z_ack_d     = z_ack_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_z_d     = rsp_z_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    op_d        = op_e'(cmd_op);
                    if (op_e'(cmd_op) == OP_ILL) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_z_d     = '0;
                        state_d     = ST_RESP;
                    end else begin
                        sel_d    = op_onehot(op_e'(cmd_op));
                        unit_a_d = cmd_a;
                        unit_b_d = cmd_b;
                        a_stb_d  = op_onehot(op_e'(cmd_op));
                        state_d  = ST_SEND_A;
                    end
                end
            end
            ST_SEND_A: begin
                if ((unit_a_ack & sel_q) != 3'b000) begin
                    a_stb_d = 3'b000;
                    b_stb_d = sel_q;
                    state_d = ST_SEND_B;
                end
            end
            ST_SEND_B: begin
                if ((unit_b_ack & sel_q) != 3'b000) begin
                    b_stb_d = 3'b000;
                    state_d = ST_WAIT_Z;
                end
            end
            ST_WAIT_Z: begin
                if ((unit_z_stb & sel_q) != 3'b000) begin
                    rsp_z_d     = z_sel;
                    rsp_err_d   = 1'b0;
                    z_ack_d     = sel_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (wdog_expired) begin
                    rsp_z_d     = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                // The z ack raised on WAIT_Z exit lives for exactly the first RESP cycle.
                z_ack_d = 3'b000;
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            sel_q       <= 3'b000;
            cmd_ready_q <= 1'b1;
            unit_a_q    <= '0;
            unit_b_q    <= '0;
            a_stb_q     <= 3'b000;
            b_stb_q     <= 3'b000;
            z_ack_q     <= 3'b000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_z_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sel_q       <= sel_d;
            cmd_ready_q <= cmd_ready_d;
            unit_a_q    <= unit_a_d;
            unit_b_q    <= unit_b_d;
            a_stb_q     <= a_stb_d;
            b_stb_q     <= b_stb_d;
            z_ack_q     <= z_ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_z_q     <= rsp_z_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign unit_a     = unit_a_q;
    assign unit_b     = unit_b_q;
    assign unit_a_stb = a_stb_q;
    assign unit_b_stb = b_stb_q;
    assign unit_z_ack = z_ack_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_z      = rsp_z_q;

endmodule
